// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the downstream sequence detector:
// state encodings, default word width and common reset values.
package seq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StPar   = 2'd2
    } seq_state_e;

    localparam int unsigned SeqWidthDefault = 8;

    localparam logic       ClrActive = 1'b1;
    localparam logic       XRst      = 1'b0;
    localparam logic       XValidRst = 1'b0;
    localparam logic       DoneRst   = 1'b0;
    localparam seq_state_e StateRst  = StIdle;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Parallel word handshake into the serializer (valid/ready).
interface seq_bit_serializer_if
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = SeqWidthDefault
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/seq_bit_counter.sv
// Loadable down-counter with zero flag; load has priority and it never wraps below zero.
module seq_bit_counter
    import seq_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr == ClrActive) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && !zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
endmodule

// File: rtl/seq_bit_serializer.sv
// MSB-first word serializer with gapless back-to-back words.
// Define SEQ_SER_PARITY_EN to append an even-parity bit (PAR state) after each word.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = SeqWidthDefault
) (
    input  logic                clk,
    input  logic                clr,
    seq_bit_serializer_if.slave in_if,
    output logic                x,
    output logic                x_valid,
    output logic                done,
    output logic                busy
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero, cnt_one, cnt_dec;
    logic             ready, accept, last_bit, par_bit;

    seq_bit_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk     (clk),
        .clr     (clr),
        .load    (accept),
        .load_val(CNT_W'(WIDTH)),
        .dec     (cnt_dec),
        .cnt     (cnt),
        .zero    (cnt_zero)
    );

    assign cnt_one = (cnt == CNT_W'(1));

`ifdef SEQ_SER_PARITY_EN
    logic par_q, par_d;

    assign last_bit = (state_q == StPar);
    assign par_d    = accept ? ^in_if.din : par_q;
    assign par_bit  = par_q;

    always_ff @(posedge clk) begin
        if (clr == ClrActive) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`else
    assign last_bit = (state_q == StShift) && cnt_one;
    assign par_bit  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (clr == ClrActive) begin
            state_q <= StateRst;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unreachable encodings fall back to idle
    always_comb begin
        state_d = StIdle;
        case (state_q)
            StIdle: state_d = accept ? StShift : StIdle;
            StShift: begin
                if (accept) begin
                    state_d = StShift;
                end else if (cnt_one) begin
`ifdef SEQ_SER_PARITY_EN
                    state_d = StPar;
`else
                    state_d = StIdle;
`endif
                end else begin
                    state_d = StShift;
                end
            end
`ifdef SEQ_SER_PARITY_EN
            StPar: state_d = accept ? StShift : StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    // Handshake and counter control
    always_comb begin
        ready           = !clr && ((state_q == StIdle) || last_bit);
        in_if.din_ready = ready;
        accept          = in_if.din_valid && ready;
        busy            = (state_q != StIdle);
        cnt_dec         = !accept && !cnt_zero && (state_q == StShift);
    end

    // Registered serial outputs are computed from the state the next cycle will be in
    always_comb begin
        sr_d = sr_q;
        if (accept) begin
            sr_d = in_if.din;
        end else if (state_q == StShift) begin
            sr_d = sr_q << 1;
        end

        x_d       = 1'b0;
        x_valid_d = 1'b0;
        if (state_d == StShift) begin
            x_d       = sr_d[WIDTH-1];
            x_valid_d = 1'b1;
        end else if (state_d == StPar) begin
            x_d       = par_bit;
            x_valid_d = 1'b1;
        end

`ifdef SEQ_SER_PARITY_EN
        done_d = (state_d == StPar);
`else
        done_d = (state_d == StShift) && !accept && (cnt == CNT_W'(2));
`endif
    end

    always_ff @(posedge clk) begin
        if (clr == ClrActive) begin
            sr_q      <= '0;
            x_q       <= XRst;
            x_valid_q <= XValidRst;
            done_q    <= DoneRst;
        end else begin
            sr_q      <= sr_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            done_q    <= done_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign done    = done_q;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: bit-queue reference model, vector table, corner sequences, random.
module tb_seq_bit_serializer;

    localparam int unsigned W = 8;

    logic clk;
    logic clr;
    logic x, x_valid, done, busy;

    seq_bit_serializer_if #(.WIDTH(W)) bus ();

    seq_bit_serializer #(
        .WIDTH(W)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .in_if  (bus),
        .x      (x),
        .x_valid(x_valid),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: queue of bits still to appear on x; front is the bit shown this cycle
    typedef struct {
        logic b;
        logic d;
    } bit_t;
    bit_t q[$];

    typedef struct {
        logic       c;
        logic       v;
        logic [7:0] din;
        logic       x;
        logic       xv;
        logic       dn;
        logic       bsy;
        logic       rdy;
    } vec_t;
    vec_t tbl[10];

    int n_pass  = 0;
    int n_total = 0;

    logic s_rdy, s_x, s_xv, s_dn, s_bsy;
    int   xv_cnt, done_cnt, ones_cnt, rise_cnt;
    logic prev_xv;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic push_word(input logic [7:0] d);
        for (int i = W - 1; i >= 0; i--) begin
            bit_t e;
            e.b = d[i];
`ifdef SEQ_SER_PARITY_EN
            e.d = 1'b0;
`else
            e.d = (i == 0);
`endif
            q.push_back(e);
        end
`ifdef SEQ_SER_PARITY_EN
        begin
            bit_t p;
            p.b = ^d;
            p.d = 1'b1;
            q.push_back(p);
        end
`endif
    endtask

    // One clock: apply inputs, check ready, advance model at the edge, check outputs
    task automatic cycle(input logic c, input logic v, input logic [7:0] d);
        logic exp_rdy, ex, exv, ed, eb;
        clr           = c;
        bus.din_valid = v;
        bus.din       = d;
        #1;
        exp_rdy = !c && (q.size() <= 1);
        s_rdy   = bus.din_ready;
        check("din_ready", int'(s_rdy), int'(exp_rdy));
        @(posedge clk);
        if (c) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (v && exp_rdy) push_word(d);
        end
        #1;
        s_x   = x;
        s_xv  = x_valid;
        s_dn  = done;
        s_bsy = busy;
        if (q.size() > 0) begin
            ex = q[0].b; exv = 1'b1; ed = q[0].d; eb = 1'b1;
        end else begin
            ex = 1'b0; exv = 1'b0; ed = 1'b0; eb = 1'b0;
        end
        check("x", int'(s_x), int'(ex));
        check("x_valid", int'(s_xv), int'(exv));
        check("done", int'(s_dn), int'(ed));
        check("busy", int'(s_bsy), int'(eb));
        if (s_xv) xv_cnt++;
        if (s_dn) done_cnt++;
        if (s_xv && s_x) ones_cnt++;
        if (s_xv && !prev_xv) rise_cnt++;
        prev_xv = s_xv;
    endtask

    task automatic clear_stats();
        xv_cnt = 0; done_cnt = 0; ones_cnt = 0; rise_cnt = 0;
    endtask

    initial begin
        clr = 1'b1; bus.din_valid = 1'b0; bus.din = '0;
        prev_xv = 1'b0;
        clear_stats();

        // Reset held with din_valid high: nothing accepted
        repeat (3) cycle(1'b1, 1'b1, 8'h5A);
        check("rst_x_valid", int'(s_xv), 0);
        check("rst_busy", int'(s_bsy), 0);

`ifndef SEQ_SER_PARITY_EN
        // Single word 0xA5: bits 1,0,1,0,0,1,0,1 then idle
        tbl[0] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].c, tbl[i].v, tbl[i].din);
            check($sformatf("tbl%0d_rdy", i), int'(s_rdy), int'(tbl[i].rdy));
            check($sformatf("tbl%0d_x", i), int'(s_x), int'(tbl[i].x));
            check($sformatf("tbl%0d_xv", i), int'(s_xv), int'(tbl[i].xv));
            check($sformatf("tbl%0d_done", i), int'(s_dn), int'(tbl[i].dn));
            check($sformatf("tbl%0d_busy", i), int'(s_bsy), int'(tbl[i].bsy));
        end

        // Back-to-back 0xFF then 0x00 with din_valid held: one contiguous 16-bit burst
        clear_stats();
        cycle(1'b0, 1'b1, 8'hFF);
        repeat (8) cycle(1'b0, 1'b1, 8'h00);
        repeat (10) cycle(1'b0, 1'b0, 8'h00);
        check("b2b_xv_cycles", xv_cnt, 16);
        check("b2b_done_pulses", done_cnt, 2);
        check("b2b_ones", ones_cnt, 8);
        check("b2b_bursts", rise_cnt, 1);
`else
        // Parity: 0x07 -> parity 1 on 9th cycle, 0x03 -> parity 0
        cycle(1'b0, 1'b1, 8'h07);
        repeat (8) cycle(1'b0, 1'b0, 8'h00);
        check("par07_x", int'(s_x), 1);
        check("par07_done", int'(s_dn), 1);
        repeat (2) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h03);
        repeat (8) cycle(1'b0, 1'b0, 8'h00);
        check("par03_x", int'(s_x), 0);
        check("par03_done", int'(s_dn), 1);
        repeat (2) cycle(1'b0, 1'b0, 8'h00);
`endif

        // clr mid-word discards the word; next word runs cleanly
        cycle(1'b0, 1'b1, 8'hC3);
        repeat (3) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        check("clr_mid_xv", int'(s_xv), 0);
        check("clr_mid_busy", int'(s_bsy), 0);
        clear_stats();
        cycle(1'b0, 1'b1, 8'h81);
        repeat (12) cycle(1'b0, 1'b0, 8'h00);
        check("after_clr_ones", ones_cnt, 2);
        check("after_clr_done", done_cnt, 1);

        // din_valid toggling with changing din while a word is in flight
        cycle(1'b0, 1'b1, 8'h3C);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'(i % 2), 8'($urandom));
        repeat (4) cycle(1'b0, 1'b0, 8'h00);

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), 8'($urandom));
        end
        repeat (12) cycle(1'b0, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
